// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// Latency: one cycle; the word at the PC appears on o_ifid_* after the next rising edge.
// Backpressure: i_stall holds the PC and IF/ID. i_br_taken overrides i_stall. HALT is sticky until reset.
//
// Ports:
//   i_clk, i_reset_n        clock and asynchronous active-low reset
//   i_stall, i_flush        hold request and bubble request
//   i_br_taken, i_br_target PC redirect request and its byte address
//   o_imem_addr             combinational instruction-memory address (the PC)
//   i_imem_instr            instruction word returned for o_imem_addr
//   o_ifid_*                IF/ID register: instr, pc, pc+4 and valid
//   o_fetch_err             sticky illegal-fetch-address flag
//   o_fetch_count           number of valid instructions written into IF/ID
module instr_fetch #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_br_taken,
  input  logic [63:0] i_br_target,
  output logic [63:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic [31:0] o_ifid_instr,
  output logic [63:0] o_ifid_pc,
  output logic [63:0] o_ifid_pc4,
  output logic        o_ifid_valid,
  output logic        o_fetch_err,
  output logic [31:0] o_fetch_count
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [63:0] r_ifid_pc;
  logic [63:0] r_ifid_pc4;
  logic        r_ifid_valid;
  logic        r_fetch_err;
  logic [31:0] r_fetch_count;

  logic [63:0] w_pc_plus4;
  logic [63:0] w_pc_plus3;
  logic        w_pc_illegal;
  logic [63:0] w_pc_nxt;
  logic        w_ifid_we;
  logic [31:0] w_ifid_instr_nxt;
  logic [63:0] w_ifid_pc_nxt;
  logic [63:0] w_ifid_pc4_nxt;
  logic        w_ifid_valid_nxt;
  logic        w_err_set;

  assign w_pc_plus4 = r_pc + 64'd4;
  assign w_pc_plus3 = r_pc + 64'd3;
  // An aligned PC cannot wrap on +3, so the unsigned compare is exact whenever alignment passes.
  assign w_pc_illegal = (r_pc[1:0] != 2'b00) || (w_pc_plus3 >= IMEM_LIMIT);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = w_pc_illegal ? S_HALT : S_RUN;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Output logic: next PC and IF/ID contents. The default is a bubble with the PC held.
  always_comb begin
    w_pc_nxt         = r_pc;
    w_ifid_we        = 1'b1;
    w_ifid_instr_nxt = 32'd0;
    w_ifid_pc_nxt    = r_pc;
    w_ifid_pc4_nxt   = w_pc_plus4;
    w_ifid_valid_nxt = 1'b0;
    w_err_set        = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_pc_illegal) begin
          w_err_set = 1'b1;
        end else if (i_br_taken) begin
          w_pc_nxt = i_br_target;
        end else if (i_stall) begin
          // A flush during a stall still bubbles IF/ID; otherwise IF/ID keeps its contents.
          w_ifid_we = i_flush;
        end else begin
          w_pc_nxt = w_pc_plus4;
          if (!i_flush) begin
            w_ifid_instr_nxt = i_imem_instr;
            w_ifid_valid_nxt = 1'b1;
          end
        end
      end
      default: begin
        // BOOT and HALT both write a bubble and hold the PC.
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc          <= RESET_PC;
      r_ifid_instr  <= 32'd0;
      r_ifid_pc     <= 64'd0;
      r_ifid_pc4    <= 64'd0;
      r_ifid_valid  <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ifid_we) begin
        r_ifid_instr <= w_ifid_instr_nxt;
        r_ifid_pc    <= w_ifid_pc_nxt;
        r_ifid_pc4   <= w_ifid_pc4_nxt;
        r_ifid_valid <= w_ifid_valid_nxt;
      end
      if (w_err_set) begin
        r_fetch_err <= 1'b1;
      end
      if (w_ifid_we && w_ifid_valid_nxt) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_ifid_instr  = r_ifid_instr;
  assign o_ifid_pc     = r_ifid_pc;
  assign o_ifid_pc4    = r_ifid_pc4;
  assign o_ifid_valid  = r_ifid_valid;
  assign o_fetch_err   = r_fetch_err;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational instruction memory whose word at byte address A is 0xA5000000 ^ A.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: stall, flush and branch are driven from directed sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_pc;
  logic [63:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'hA500_0000 ^ imem_addr[31:0];

  instr_fetch #(
    .RESET_PC   (64'd0),
    .IMEM_BYTES (1024)
  ) u_dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .o_imem_addr   (imem_addr),
    .i_imem_instr  (imem_instr),
    .o_ifid_instr  (ifid_instr),
    .o_ifid_pc     (ifid_pc),
    .o_ifid_pc4    (ifid_pc4),
    .o_ifid_valid  (ifid_valid),
    .o_fetch_err   (fetch_err),
    .o_fetch_count (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                          input logic valid);
    chk({tag, ".instr"}, ifid_instr, instr);
    chk({tag, ".pc"},    ifid_pc,    pc);
    chk({tag, ".pc4"},   ifid_pc4,   pc + 64'd4);
    chk({tag, ".valid"}, ifid_valid, valid);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".addr"},  imem_addr,   64'd0);
    chk({tag, ".instr"}, ifid_instr,  32'd0);
    chk({tag, ".pc"},    ifid_pc,     64'd0);
    chk({tag, ".pc4"},   ifid_pc4,    64'd0);
    chk({tag, ".valid"}, ifid_valid,  1'b0);
    chk({tag, ".err"},   fetch_err,   1'b0);
    chk({tag, ".count"}, fetch_count, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    br_taken  = 1'b0;
    br_target = 64'd0;

    // Reset values appear with no clock edge.
    #2;
    chk_reset_vals("rst");

    // Release between edges; first edge is the BOOT cycle.
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    chk_ifid("boot", 32'd0, 64'd0, 1'b0);
    chk("boot.addr", imem_addr, 64'd0);

    step();
    chk_ifid("seq0", 32'hA500_0000, 64'd0, 1'b1);
    step();
    chk_ifid("seq4", 32'hA500_0004, 64'd4, 1'b1);
    chk("seq4.addr", imem_addr, 64'd8);

    // Stall at PC=8 for two cycles, flushing in the second.
    stall = 1'b1;
    step();
    chk("stall1.addr", imem_addr, 64'd8);
    chk_ifid("stall1", 32'hA500_0004, 64'd4, 1'b1);
    flush = 1'b1;
    step();
    chk("stall2.addr", imem_addr, 64'd8);
    chk_ifid("stallfl", 32'd0, 64'd8, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    chk_ifid("unstall", 32'hA500_0008, 64'd8, 1'b1);
    chk("unstall.count", fetch_count, 32'd3);
    chk("unstall.addr", imem_addr, 64'd12);

    // Branch at PC=12 beats stall and flush.
    br_taken  = 1'b1;
    br_target = 64'h40;
    stall     = 1'b1;
    flush     = 1'b1;
    step();
    chk("br.addr", imem_addr, 64'h40);
    chk_ifid("br", 32'd0, 64'd12, 1'b0);
    chk("br.count", fetch_count, 32'd3);
    br_taken = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    step();
    chk_ifid("brtgt", 32'hA500_0040, 64'h40, 1'b1);
    chk("brtgt.count", fetch_count, 32'd4);

    // Flush without stall: bubble but PC advances.
    flush = 1'b1;
    step();
    chk_ifid("seqfl", 32'd0, 64'h44, 1'b0);
    chk("seqfl.addr", imem_addr, 64'h48);
    chk("seqfl.count", fetch_count, 32'd4);
    flush = 1'b0;
    step();
    chk_ifid("postfl", 32'hA500_0048, 64'h48, 1'b1);
    chk("postfl.count", fetch_count, 32'd5);

    // Misaligned branch target is accepted, then halts on the next edge.
    br_taken  = 1'b1;
    br_target = 64'h42;
    step();
    chk("badbr.addr", imem_addr, 64'h42);
    chk("badbr.err", fetch_err, 1'b0);
    br_taken = 1'b0;
    step();
    chk("halt.err", fetch_err, 1'b1);
    chk_ifid("halt", 32'd0, 64'h42, 1'b0);

    // HALT ignores branches and stalls for 10 cycles.
    br_taken  = 1'b1;
    br_target = 64'h0;
    for (int i = 0; i < 10; i++) begin
      stall = i[0];
      step();
    end
    br_taken = 1'b0;
    stall    = 1'b0;
    chk("halt10.addr", imem_addr, 64'h42);
    chk("halt10.err", fetch_err, 1'b1);
    chk("halt10.valid", ifid_valid, 1'b0);
    chk("halt10.count", fetch_count, 32'd5);

    // Reset pulse strictly between edges while halted.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rstpulse");
    #1;
    reset_n = 1'b1;
    step();
    chk_ifid("reboot", 32'd0, 64'd0, 1'b0);
    step();
    chk_ifid("refetch", 32'hA500_0000, 64'd0, 1'b1);
    chk("refetch.count", fetch_count, 32'd1);

    // Run sequentially to the last legal word.
    for (int i = 0; i < 300 && imem_addr != 64'd1020; i++) begin
      step();
    end
    chk("reach1020", imem_addr, 64'd1020);
    step();
    chk_ifid("last", 32'hA500_03FC, 64'd1020, 1'b1);
    chk("last.err", fetch_err, 1'b0);
    chk("last.addr", imem_addr, 64'd1024);
    chk("last.count", fetch_count, 32'd256);
    step();
    chk("end.err", fetch_err, 1'b1);
    chk("end.valid", ifid_valid, 1'b0);
    chk("end.count", fetch_count, 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
